// File: rtl/renode_apb3_arbiter.sv
// Round-robin N:1 APB3 arbiter: serializes requester transfers onto one
// completer port, with an optional wait-state timeout that forces an error.
module renode_apb3_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 0
) (
  input  logic                                       pclk,
  input  logic                                       presetn,
  input  logic [NumRequesters-1:0][AddressWidth-1:0] s_paddr,
  input  logic [NumRequesters-1:0]                   s_psel,
  input  logic [NumRequesters-1:0]                   s_penable,
  input  logic [NumRequesters-1:0]                   s_pwrite,
  input  logic [NumRequesters-1:0][DataWidth-1:0]    s_pwdata,
  output logic [NumRequesters-1:0]                   s_pready,
  output logic [NumRequesters-1:0][DataWidth-1:0]    s_prdata,
  output logic [NumRequesters-1:0]                   s_pslverr,
  output logic [AddressWidth-1:0]                    m_paddr,
  output logic                                       m_psel,
  output logic                                       m_penable,
  output logic                                       m_pwrite,
  output logic [DataWidth-1:0]                       m_pwdata,
  input  logic                                       m_pready,
  input  logic [DataWidth-1:0]                       m_prdata,
  input  logic                                       m_pslverr
);

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TimeoutEn = TimeoutCycles > 0;
  localparam logic [CntW-1:0] WaitLast =
    CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] WaitMax = CntW'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         rr_q, rr_d;
  logic [IdxW-1:0]         grant_q, grant_d;
  logic [CntW-1:0]         wait_q, wait_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;

  logic                    pick_vld;
  logic [IdxW-1:0]         pick_idx;
  logic [IdxW-1:0]         cand;
  logic                    done;
  logic                    forced;

  function automatic logic [IdxW-1:0] wrap_inc(
    input logic [IdxW-1:0] v
  );
    return (int'(v) == NumRequesters - 1) ? '0 : v + IdxW'(1);
  endfunction

  // First requesting index at or above rr_q, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_q;
    cand     = rr_q;
    for (int k = 0; k < NumRequesters; k++) begin
      if (!pick_vld && s_psel[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    forced  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = s_paddr[pick_idx];
          write_d = s_pwrite[pick_idx];
          wdata_d = s_pwdata[pick_idx];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (m_pready) begin
          done = 1'b1;
        end else if (TimeoutEn && wait_q == WaitLast) begin
          done   = 1'b1;
          forced = 1'b1;
        end else if (wait_q != WaitMax) begin
          wait_d = wait_q + CntW'(1);
        end
        if (done) begin
          state_d = IDLE;
          rr_d    = wrap_inc(grant_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Response is routed only to the winner, only in its completion cycle.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    if (done) begin
      s_pready[grant_q]  = 1'b1;
      s_pslverr[grant_q] = forced | m_pslverr;
      s_prdata[grant_q]  = (forced | write_q) ? '0 : m_prdata;
    end
  end

  assign m_psel    = (state_q != IDLE);
  assign m_penable = (state_q == ACCESS);
  assign m_paddr   = m_psel ? addr_q : '0;
  assign m_pwrite  = m_psel & write_q;
  assign m_pwdata  = (m_psel && write_q) ? wdata_q : '0;

  assert property (@(posedge pclk) disable iff (!presetn)
    (s_penable & ~s_psel) == '0);

endmodule
